// File: rtl/fft_pkg.sv
// Shared types, constants and address helper for the 8-point FFT sequencer.
// The helper maps (stage, butterfly) to operand and twiddle addresses.
package fft_pkg;

    localparam int FFT_N     = 8;
    localparam int FFT_LOG2N = 3;
    localparam int ADDR_W    = 3;
    localparam int TW_W      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
        logic [TW_W-1:0]   k;
    } bf_t;

    // In-place DIT addressing: pairs are 'half' apart inside groups of 2*half.
    function automatic bf_t bf_addr(input logic [1:0] s, input logic [1:0] j);
        bf_t        r;
        logic [2:0] half;
        logic [2:0] pos;
        logic [2:0] grp;
        logic [2:0] kk;
        half = 3'd1 << s;
        pos  = {1'b0, j} & (half - 3'd1);
        grp  = {1'b0, j} >> s;
        r.a  = ((grp << s) << 1) + pos;
        r.b  = r.a + half;
        kk   = pos << (2'd2 - s);
        r.k  = kk[1:0];
        return r;
    endfunction

endpackage

// File: rtl/fft_ctrl_delay.sv
// Clearable shift register aligning read-side strobes/addresses
// with butterfly results for write-back.
module fft_ctrl_delay #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr [DEPTH];

    // Shift every cycle; clear drops in-flight entries so nothing is written.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/fft8_ctrl.sv
// Sequencer for an in-place radix-2 DIT 8-point FFT: issues 3 stages of
// 4 butterflies, drains the pipeline between stages, delays writes.
module fft8_ctrl
    import fft_pkg::*;
#(
    parameter int BF_LAT = 2,
    parameter int LOG2N  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic [TW_W-1:0]   tw_addr,
    output logic [1:0]        stage,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_a,
    output logic [ADDR_W-1:0] wr_addr_b
);

    localparam int         DEPTH    = 1 + BF_LAT;
    localparam logic [3:0] DLAST    = 4'(BF_LAT);
    localparam logic [1:0] LAST_STG = 2'(LOG2N - 1);
    localparam int         DW       = 1 + 2 * ADDR_W;

    state_t      state, state_nx;
    logic [1:0]  stg, stg_nx;
    logic [1:0]  j, j_nx;
    logic [3:0]  dcnt, dcnt_nx;
    bf_t         bf;
    logic [DW-1:0] wr_bus;

    // State, stage, butterfly and drain counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            stg   <= '0;
            j     <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_nx;
            stg   <= stg_nx;
            j     <= j_nx;
            dcnt  <= dcnt_nx;
        end
    end

    // Next-state: drain lasts DLAST+1 cycles so the last write lands first.
    always_comb begin
        state_nx = state;
        stg_nx   = stg;
        j_nx     = j;
        dcnt_nx  = dcnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    stg_nx   = '0;
                    j_nx     = '0;
                end
            end
            RUN: begin
                if (j == 2'd3) begin
                    state_nx = DRAIN;
                    dcnt_nx  = '0;
                end else begin
                    j_nx = j + 2'd1;
                end
            end
            DRAIN: begin
                if (dcnt == DLAST) begin
                    if (stg == LAST_STG) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = RUN;
                        stg_nx   = stg + 2'd1;
                        j_nx     = '0;
                    end
                end else begin
                    dcnt_nx = dcnt + 4'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bf        = bf_addr(stg, j);
    assign rd_en     = (state == RUN);
    assign rd_addr_a = rd_en ? bf.a : '0;
    assign rd_addr_b = rd_en ? bf.b : '0;
    assign tw_addr   = rd_en ? bf.k : '0;
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign stage     = busy ? stg : '0;

    fft_ctrl_delay #(
        .WIDTH(DW),
        .DEPTH(DEPTH)
    ) u_delay (
        .clk(clk),
        .clr(rst),
        .d  ({rd_en, rd_addr_a, rd_addr_b}),
        .q  (wr_bus)
    );

    assign wr_en     = wr_bus[DW-1];
    assign wr_addr_a = wr_bus[2*ADDR_W-1:ADDR_W];
    assign wr_addr_b = wr_bus[ADDR_W-1:0];

endmodule

// File: tb/tb_fft8_ctrl.sv
// Directed bench for fft8_ctrl: address table, cycle-exact schedule for
// BF_LAT 1/2/5, ignored starts, mid-run reset, back-to-back transforms.
module tb_fft8_ctrl;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start_x = 1'b0;

    always #5 clk = ~clk;

    logic       b2, d2, re2, we2;
    logic [2:0] a2, bb2, wa2, wb2;
    logic [1:0] k2, st2;
    logic       b1, d1, re1, we1;
    logic [2:0] a1, bb1, wa1, wb1;
    logic [1:0] k1, st1;
    logic       b5, d5, re5, we5;
    logic [2:0] a5, bb5, wa5, wb5;
    logic [1:0] k5, st5;

    fft8_ctrl #(.BF_LAT(2)) u2 (
        .clk(clk), .rst(rst), .start(start), .busy(b2), .done(d2),
        .rd_en(re2), .rd_addr_a(a2), .rd_addr_b(bb2), .tw_addr(k2),
        .stage(st2), .wr_en(we2), .wr_addr_a(wa2), .wr_addr_b(wb2)
    );
    fft8_ctrl #(.BF_LAT(1)) u1 (
        .clk(clk), .rst(rst), .start(start_x), .busy(b1), .done(d1),
        .rd_en(re1), .rd_addr_a(a1), .rd_addr_b(bb1), .tw_addr(k1),
        .stage(st1), .wr_en(we1), .wr_addr_a(wa1), .wr_addr_b(wb1)
    );
    fft8_ctrl #(.BF_LAT(5)) u5 (
        .clk(clk), .rst(rst), .start(start_x), .busy(b5), .done(d5),
        .rd_en(re5), .rd_addr_a(a5), .rd_addr_b(bb5), .tw_addr(k5),
        .stage(st5), .wr_en(we5), .wr_addr_a(wa5), .wr_addr_b(wb5)
    );

    logic [19:0] v2, v1, v5;
    assign v2 = {b2, d2, re2, a2, bb2, k2, st2, we2, wa2, wb2};
    assign v1 = {b1, d1, re1, a1, bb1, k1, st1, we1, wa1, wb1};
    assign v5 = {b5, d5, re5, a5, bb5, k5, st5, we5, wa5, wb5};

    typedef struct {
        int         s;
        int         j;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] k;
    } vec_t;

    vec_t tab[12];
    int total = 0;
    int bad = 0;
    int nwr, ndone;

    task automatic chk(input string nm, input int c,
                       input logic [19:0] got, input logic [19:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s c=%0d got=%h exp=%h", nm, c, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected packed outputs in cycle c after start sampled at edge 0.
    function automatic logic [19:0] expv(input int lat, input int c);
        int P, s, off, rc, idx;
        logic [19:0] v;
        P = 5 + lat;
        v = '0;
        if (c >= 1 && c <= 3 * P) begin
            s = (c - 1) / P;
            off = (c - 1) % P;
            v[19] = 1'b1;
            v[8:7] = 2'(s);
            if (off < 4) begin
                idx = s * 4 + off;
                v[17] = 1'b1;
                v[16:14] = tab[idx].a;
                v[13:11] = tab[idx].b;
                v[10:9] = tab[idx].k;
            end
            rc = c - 1 - lat;
            if (rc >= 1 && ((rc - 1) % P) < 4) begin
                idx = ((rc - 1) / P) * 4 + (rc - 1) % P;
                v[6] = 1'b1;
                v[5:3] = tab[idx].a;
                v[2:0] = tab[idx].b;
            end
        end
        if (c == 3 * P + 1) v[18] = 1'b1;
        return v;
    endfunction

    initial begin
        bf_t r;
        tab[0]  = '{0, 0, 3'd0, 3'd1, 2'd0};
        tab[1]  = '{0, 1, 3'd2, 3'd3, 2'd0};
        tab[2]  = '{0, 2, 3'd4, 3'd5, 2'd0};
        tab[3]  = '{0, 3, 3'd6, 3'd7, 2'd0};
        tab[4]  = '{1, 0, 3'd0, 3'd2, 2'd0};
        tab[5]  = '{1, 1, 3'd1, 3'd3, 2'd2};
        tab[6]  = '{1, 2, 3'd4, 3'd6, 2'd0};
        tab[7]  = '{1, 3, 3'd5, 3'd7, 2'd2};
        tab[8]  = '{2, 0, 3'd0, 3'd4, 2'd0};
        tab[9]  = '{2, 1, 3'd1, 3'd5, 2'd1};
        tab[10] = '{2, 2, 3'd2, 3'd6, 2'd2};
        tab[11] = '{2, 3, 3'd3, 3'd7, 2'd3};

        for (int i = 0; i < 12; i++) begin
            r = bf_addr(2'(tab[i].s), 2'(tab[i].j));
            chk("pkg_addr", i, {12'd0, r.a, r.b, r.k},
                {12'd0, tab[i].a, tab[i].b, tab[i].k});
        end

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_l2", 0, v2, 20'd0);
        chk("reset_l1", 0, v1, 20'd0);
        chk("reset_l5", 0, v5, 20'd0);

        // Plain transform on all three latencies.
        start = 1'b1;
        start_x = 1'b1;
        tick();
        start = 1'b0;
        start_x = 1'b0;
        nwr = 0;
        ndone = 0;
        for (int c = 1; c <= 34; c++) begin
            chk("sched_l2", c, v2, expv(2, c));
            chk("sched_l1", c, v1, expv(1, c));
            chk("sched_l5", c, v5, expv(5, c));
            nwr += int'(we2);
            ndone += int'(d2);
            tick();
        end
        chk("wr_count", 0, 20'(nwr), 20'd12);
        chk("done_count", 0, 20'(ndone), 20'd1);

        // Starts while busy and while in DONE are ignored.
        start = 1'b1;
        tick();
        ndone = 0;
        for (int c = 1; c <= 26; c++) begin
            start = (c == 5 || c == 20 || c == 22);
            chk("ign_start", c, v2, expv(2, c));
            ndone += int'(d2);
            tick();
        end
        start = 1'b0;
        chk("ign_done_cnt", 0, 20'(ndone), 20'd1);

        // Reset in cycle 10 kills the transform and all pending writes.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            chk("pre_rst", c, v2, expv(2, c));
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nwr = 0;
        ndone = 0;
        for (int c = 11; c <= 34; c++) begin
            chk("post_rst", c, v2, 20'd0);
            nwr += int'(we2);
            ndone += int'(d2);
            tick();
        end
        chk("post_rst_wr", 0, 20'(nwr), 20'd0);
        chk("post_rst_done", 0, 20'(ndone), 20'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            chk("restart", c, v2, expv(2, c));
            tick();
        end

        // Held start: one IDLE cycle between DONE and next busy.
        start = 1'b1;
        tick();
        for (int c = 1; c <= 50; c++) begin
            if (c == 30) start = 1'b0;
            chk("b2b", c, v2, expv(2, (c > 23) ? c - 23 : c));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft8_ctrl.md
# fft8_ctrl

Sequencer for the in-place radix-2 decimation-in-time 8-point FFT datapath. It runs 3 stages of 4 butterflies. For each butterfly it issues the two operand read addresses to the data RAM and the 2-bit address to the twiddle ROM (`twiddlefactors_8`, registered read, 1-cycle latency). It then delays those addresses to produce the write-back addresses and write enable. Between stages it inserts drain cycles so that no read of stage s+1 precedes the last write of stage s.

## Interface
Parameters:
- `BF_LAT`, default 2: butterfly pipeline latency in cycles, from ROM/RAM data valid to result valid. Legal range 1..8.
- `LOG2N`, default 3: fixed at 3. Any other value is out of scope.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request one transform. Sampled only in IDLE.
- `busy`, output, 1: high from the cycle after `start` is accepted through the final write-back cycle.
- `done`, output, 1: one-cycle pulse in the cycle after the final write-back.
- `rd_en`, output, 1: operand read strobe, one per butterfly.
- `rd_addr_a`, output, 3: upper operand address.
- `rd_addr_b`, output, 3: lower operand address.
- `tw_addr`, output, 2: twiddle ROM address k, presented in the same cycle as the read addresses.
- `stage`, output, 2: current stage 0..2 while issuing. Held during drain.
- `wr_en`, output, 1: write-back strobe.
- `wr_addr_a`, output, 3: write address for the upper result.
- `wr_addr_b`, output, 3: write address for the lower result.

## Operation
- FSM states:
  - IDLE: on `start`, go to RUN with stage=0, j=0.
  - RUN: issue one butterfly per cycle. After j=3, go to DRAIN.
  - DRAIN: count 1+`BF_LAT` cycles, then:
    - if stage<2, increment stage, set j=0, go to RUN;
    - if stage=2, go to DONE.
  - DONE: one cycle with `done`=1, then IDLE.
- Address rule, for stage s and butterfly j=0..3:
  - half = 1<<s
  - pos = j & (half-1)
  - grp = j>>s
  - `rd_addr_a` = grp·2·half + pos
  - `rd_addr_b` = `rd_addr_a` + half
  - `tw_addr` = pos << (2−s)
  - All arithmetic is unsigned and 3-bit. The expressions never exceed 7.
- `rd_en` is 1 exactly in RUN cycles. Address outputs are 0 when `rd_en`=0.
- Write path: {`rd_en`, `rd_addr_a`, `rd_addr_b`} is delayed by 1+`BF_LAT` cycles to produce {`wr_en`, `wr_addr_a`, `wr_addr_b`}. This accounts for 1 cycle of ROM/RAM read latency plus the butterfly latency. The write addresses equal the read addresses (in-place).
- `start` in any state other than IDLE is ignored. `start` held high continuously re-triggers on the cycle after DONE returns the FSM to IDLE.
- Input ordering (bit-reversed load) is the upstream loader's job. Output is in natural order.

## Timing
- Reset: all outputs are 0 and the state is IDLE. Every stage of the delay line is cleared.
- Reset mid-transform: effective at the next edge. No `wr_en` appears after reset, even for butterflies already in flight. `done` is not pulsed.
- Schedule, with `start` sampled at edge 0 and `BF_LAT`=2:
  - stage 0 issue in cycles 1–4, drain 5–7;
  - stage 1 issue in cycles 8–11, drain 12–14;
  - stage 2 issue in cycles 15–18, drain 19–21.
  - `wr_en` is high in cycles 4–7, 11–14 and 18–21.
  - `done` is high in cycle 22. `busy` is high in cycles 1–21.
- General case: period per stage P = 5+`BF_LAT`. Last write is in cycle 3P. `done` is in cycle 3P+1.
- Hazard guarantee: the first read of stage s+1 is exactly 1 cycle after the last `wr_en` of stage s. The RAM is write-then-visible on the next cycle.
- `rd_en` and `wr_en` overlap only within a stage, never across stage boundaries. They never carry colliding addresses.

## Structure
- Shared package `fft_pkg`:
  - constants `FFT_N`=8 and `FFT_LOG2N`=3;
  - address width 3 and twiddle address width 2;
  - FSM state enum {IDLE, RUN, DRAIN, DONE};
  - a pure function computing (a, b, k) from (s, j), reused by the bench model.
- Sub-module `fft_ctrl_delay`: a parameterised shift register (width, depth, synchronous clear) implementing the 1+`BF_LAT` write-path delay.
- Top level: the FSM, the j counter, the stage counter and the drain counter.

## Test plan
- Reset, then `start` pulse with `BF_LAT`=2:
  - read address sequence (a,b,k): (0,1,0) (2,3,0) (4,5,0) (6,7,0); (0,2,0) (1,3,2) (4,6,0) (5,7,2); (0,4,0) (1,5,1) (2,6,2) (3,7,3);
  - `done` in cycle 22.
- Write-back check: every `wr_en` cycle carries the read addresses from 3 cycles earlier. There are exactly 12 writes. No read occurs before the preceding stage's last write.
- `start` pulsed in cycles 5 and 20 of a transform: ignored. Exactly one `done`.
- `rst` asserted in cycle 10 for 1 cycle: all outputs are 0 from cycle 11. No `wr_en` and no `done` follows. A new `start` then produces the full correct sequence.
- `start` held high: back-to-back transforms with IDLE visible for 1 cycle between `done` and the next `busy`.
- `BF_LAT`=1 and `BF_LAT`=5: P=6 and P=10, `done` in cycles 19 and 31, address sequence unchanged.
